// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the RV32I memory stage.
//   WORD_SIZE               data width of the core (32 only)
//   SIZE_BYTE/HALF/WORD     encodings of the data_size control field
//   lsu_state_t             states of the load/store unit sequencer
package riscv_pkg;

  localparam int WORD_SIZE = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_DONE = 2'b10
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align
// Purely combinational data-path helper for the load/store unit.
//   access_size/access_lane/store_data  the access currently offered by EX/MEM
//   store_wdata/store_strb              lane-replicated store data and byte enables
//   misaligned                          access crosses its natural alignment
//   load_size/load_lane/load_sign       fields latched when the load was accepted
//   load_word                           raw word returned by data memory
//   load_data                           extracted and extended load result
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]           access_size,
  input  logic [1:0]           access_lane,
  input  logic [WORD_SIZE-1:0] store_data,
  output logic [WORD_SIZE-1:0] store_wdata,
  output logic [3:0]           store_strb,
  output logic                 misaligned,
  input  logic [1:0]           load_size,
  input  logic [1:0]           load_lane,
  input  logic                 load_sign,
  input  logic [WORD_SIZE-1:0] load_word,
  output logic [WORD_SIZE-1:0] load_data
);

  // Size 11 falls into the word branches, so it behaves exactly like a word.
  // Store data is replicated across every lane so the memory only has to
  // honour the strobes, never shift data.
  always_comb begin
    misaligned  = 1'b0;
    store_wdata = store_data;
    store_strb  = 4'b1111;
    case (access_size)
      SIZE_BYTE: begin
        store_wdata = {4{store_data[7:0]}};
        store_strb  = 4'b0001 << access_lane;
      end
      SIZE_HALF: begin
        misaligned  = access_lane[0];
        store_wdata = {2{store_data[15:0]}};
        store_strb  = access_lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        misaligned = |access_lane;
      end
    endcase
  end

  // Load extraction picks the addressed byte or halfword out of the word and
  // widens it, replicating the top bit only for signed loads.
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    load_byte = load_word[{load_lane, 3'b000} +: 8];
    load_half = load_word[{load_lane[1], 4'b0000} +: 16];
    case (load_size)
      SIZE_BYTE: load_data = {{24{load_sign & load_byte[7]}}, load_byte};
      SIZE_HALF: load_data = {{16{load_sign & load_half[15]}}, load_half};
      default:   load_data = load_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Memory-stage sequencer between EX/MEM and MEM/WB.
//   clk, rst                         clock and synchronous active-high reset
//   mem_read, mem_write              access request (write wins when both set)
//   data_size, data_sign             access width and load extension mode
//   addr, wdata                      byte address and store data
//   rdata, rdata_valid               extended load result and its update pulse
//   stall                            holds the pipeline while memory is busy
//   misaligned                       access was dropped for bad alignment
//   dmem_*                           word-addressed, byte-strobed memory port
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int WORD_SIZE = riscv_pkg::WORD_SIZE,
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [1:0]           data_size,
  input  logic                 data_sign,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 rdata_valid,
  output logic                 stall,
  output logic                 misaligned,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [ADDR_SIZE-3:0] dmem_addr,
  output logic [3:0]           dmem_wstrb,
  output logic [WORD_SIZE-1:0] dmem_wdata,
  input  logic [WORD_SIZE-1:0] dmem_rdata,
  input  logic                 dmem_ready
);

  lsu_state_t state, next_state;

  logic [ADDR_SIZE-3:0] addr_q;
  logic [1:0]           lane_q;
  logic [1:0]           size_q;
  logic                 sign_q;
  logic                 we_q;
  logic [3:0]           wstrb_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [WORD_SIZE-1:0] rdata_q;

  logic [WORD_SIZE-1:0] store_wdata;
  logic [3:0]           store_strb;
  logic                 access_misaligned;
  logic [WORD_SIZE-1:0] load_data;
  logic                 start;

  lsu_align u_align (
    .access_size (data_size),
    .access_lane (addr[1:0]),
    .store_data  (wdata),
    .store_wdata (store_wdata),
    .store_strb  (store_strb),
    .misaligned  (access_misaligned),
    .load_size   (size_q),
    .load_lane   (lane_q),
    .load_sign   (sign_q),
    .load_word   (dmem_rdata),
    .load_data   (load_data)
  );

  // Next-state and combinational handshake. A misaligned access is flagged
  // and dropped in the same cycle so the pipeline never stalls for it.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    misaligned = 1'b0;
    start      = 1'b0;
    case (state)
      LSU_IDLE: begin
        if (mem_read | mem_write) begin
          if (access_misaligned) begin
            misaligned = 1'b1;
          end else begin
            stall      = 1'b1;
            start      = 1'b1;
            next_state = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        stall = 1'b1;
        if (dmem_ready) next_state = LSU_DONE;
      end
      LSU_DONE: begin
        next_state = LSU_IDLE;
      end
      default: begin
        next_state = LSU_IDLE;
      end
    endcase
  end

  // State and request registers. The request fields are captured once on
  // acceptance so they stay stable for the whole REQ phase; loads carry an
  // all-zero strobe. rdata only moves when a load is answered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LSU_IDLE;
      addr_q  <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= next_state;
      if (start) begin
        addr_q  <= addr[ADDR_SIZE-1:2];
        lane_q  <= addr[1:0];
        size_q  <= data_size;
        sign_q  <= data_sign;
        we_q    <= mem_write;
        wstrb_q <= mem_write ? store_strb : 4'b0000;
        wdata_q <= store_wdata;
      end
      if (state == LSU_REQ && dmem_ready && !we_q) begin
        rdata_q <= load_data;
      end
    end
  end

  assign dmem_req    = (state == LSU_REQ);
  assign dmem_we     = (state == LSU_REQ) & we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wstrb  = wstrb_q;
  assign dmem_wdata  = wdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = (state == LSU_DONE) & ~we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Self-checking bench for load_store_unit. A byte-array model of memory
// predicts load results and store formatting; a word-array memory answers
// the DUT's port using only the strobes and data the DUT drives.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  data_size;
  logic        data_sign;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        stall;
  logic        misaligned;
  logic        dmem_req;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  int vectors;
  int miscompares;

  logic [7:0]  ref_mem  [0:1023];
  logic [31:0] phys_mem [0:255];
  logic [31:0] model_rdata;

  load_store_unit #(.WORD_SIZE(32), .ADDR_SIZE(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .data_size   (data_size),
    .data_sign   (data_sign),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .stall       (stall),
    .misaligned  (misaligned),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wstrb  (dmem_wstrb),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ready  (dmem_ready)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a wedged DUT can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Little-endian load from the byte model, widened as the ISA defines.
  function automatic logic [31:0] model_load(input logic [9:0] a, input logic [1:0] sz,
                                             input logic sg);
    int n;
    logic [31:0] v;
    n = size_bytes(sz);
    v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[int'(a) + k];
    if (sg && n < 4 && v[8*n-1]) begin
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    end
    return v;
  endfunction

  // One complete access as the pipeline would present it: inputs held during
  // the stall and the DONE cycle, withdrawn right after the pipeline advances.
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic sg, input logic [9:0] a, input logic [31:0] wd,
                           input int waits, input string tag);
    logic        mis, is_wr, is_rd, done;
    logic [31:0] exp_rd, exp_wdata;
    logic [3:0]  exp_strb;
    int          n, stalls, guard, w;
    is_wr = wr;
    is_rd = rd & ~wr;
    n = size_bytes(sz);
    mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    exp_rd = model_load(a, sz, sg);
    exp_strb = '0;
    exp_wdata = '0;
    for (int k = 0; k < n; k++) exp_strb[(int'(a[1:0]) + k) % 4] = 1'b1;
    for (int j = 0; j < 4; j++) exp_wdata[8*j +: 8] = wd[8*(j % n) +: 8];

    mem_read = rd; mem_write = wr; data_size = sz; data_sign = sg; addr = a; wdata = wd;
    #1;
    if (!(rd | wr)) begin
      @(negedge clk);
      return;
    end

    if (mis) begin
      vectors++;
      if (misaligned !== 1'b1 || stall !== 1'b0 || dmem_req !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL %s mis_flag: misaligned=%b stall=%b req=%b, want 1 0 0",
                 tag, misaligned, stall, dmem_req);
      end
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      vectors++;
      if (misaligned !== 1'b0 || dmem_req !== 1'b0 || rdata_valid !== 1'b0 ||
          rdata !== model_rdata) begin
        miscompares++;
        $display("[TB] FAIL %s mis_after: mis=%b req=%b valid=%b rdata=%h, want 0 0 0 %h",
                 tag, misaligned, dmem_req, rdata_valid, rdata, model_rdata);
      end
      return;
    end

    vectors++;
    if (stall !== 1'b1 || misaligned !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s idle_stall: stall=%b mis=%b, want 1 0", tag, stall, misaligned);
    end
    stalls = 1;
    w = waits;
    guard = 0;
    done = 1'b0;
    @(negedge clk);
    forever begin
      stalls += int'(stall);
      vectors++;
      if (dmem_req !== 1'b1 || dmem_addr !== a[9:2] || dmem_we !== is_wr ||
          dmem_wstrb !== (is_wr ? exp_strb : 4'b0000) ||
          (is_wr && dmem_wdata !== exp_wdata)) begin
        miscompares++;
        $display("[TB] FAIL %s req_fields: req=%b addr=%h we=%b strb=%b wdata=%h, want 1 %h %b %b %h",
                 tag, dmem_req, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
                 a[9:2], is_wr, is_wr ? exp_strb : 4'b0000, exp_wdata);
      end
      if (w > 0) begin
        dmem_ready = 1'b0;
        dmem_rdata = $urandom;
        w--;
      end else begin
        dmem_ready = 1'b1;
        dmem_rdata = phys_mem[dmem_addr];
        if (dmem_we === 1'b1) begin
          for (int j = 0; j < 4; j++)
            if (dmem_wstrb[j]) phys_mem[dmem_addr][8*j +: 8] = dmem_wdata[8*j +: 8];
        end
        done = 1'b1;
      end
      @(negedge clk);
      guard++;
      if (done) break;
      if (guard > 40) begin
        miscompares++;
        vectors++;
        $display("[TB] FAIL %s timeout: no completion within 40 cycles", tag);
        break;
      end
    end
    dmem_ready = 1'b0;

    if (is_wr) begin
      for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
    end else begin
      model_rdata = exp_rd;
    end
    vectors++;
    if (stall !== 1'b0 || dmem_req !== 1'b0 || rdata_valid !== is_rd ||
        rdata !== model_rdata || stalls != waits + 2) begin
      miscompares++;
      $display("[TB] FAIL %s done: stall=%b req=%b valid=%b rdata=%h stalls=%0d, want 0 0 %b %h %0d",
               tag, stall, dmem_req, rdata_valid, rdata, stalls, is_rd, model_rdata, waits + 2);
    end
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    vectors++;
    if (rdata_valid !== 1'b0 || dmem_req !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s after_done: valid=%b req=%b stall=%b, want 0 0 0",
               tag, rdata_valid, dmem_req, stall);
    end
  endtask

  task automatic idle_cycle();
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; data_size = 2'b00; data_sign = 1'b0;
    addr = '0; wdata = '0; dmem_rdata = '0; dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (rdata !== 32'h0 || rdata_valid !== 1'b0 || stall !== 1'b0 || misaligned !== 1'b0 ||
        dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_wstrb !== 4'h0 ||
        dmem_addr !== 8'h0 || dmem_wdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_values: rdata=%h valid=%b stall=%b mis=%b req=%b we=%b strb=%b addr=%h wdata=%h, want all 0",
               rdata, rdata_valid, stall, misaligned, dmem_req, dmem_we, dmem_wstrb,
               dmem_addr, dmem_wdata);
    end
    rst = 1'b0;
    model_rdata = '0;
    @(negedge clk);
  endtask

  task automatic test_byte_store();
    do_access(1'b0, 1'b1, 2'b10, 1'b0, 10'h040, 32'h11223344, 0, "sw_040");
    do_access(1'b0, 1'b1, 2'b00, 1'b0, 10'h041, 32'h000000AB, 0, "sb_041");
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 10'h040, 32'h0, 0, "lw_040");
    vectors++;
    if (rdata !== 32'h1122AB44) begin
      miscompares++;
      $display("[TB] FAIL lw_040_value: rdata=%h, want 1122ab44", rdata);
    end
  endtask

  task automatic test_sign_ext();
    logic [31:0] want [4];
    logic [9:0]  la   [4];
    logic [1:0]  ls   [4];
    logic        lsg  [4];
    want = '{32'hFFFFFF81, 32'h00000081, 32'hFFFF80F0, 32'h000080F0};
    la   = '{10'h100, 10'h100, 10'h102, 10'h102};
    ls   = '{2'b00, 2'b00, 2'b01, 2'b01};
    lsg  = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_access(1'b0, 1'b1, 2'b10, 1'b0, 10'h100, 32'h80F07F81, 0, "sw_100");
    for (int i = 0; i < 4; i++) begin
      do_access(1'b1, 1'b0, ls[i], lsg[i], la[i], 32'h0, 0, "ld_ext");
      vectors++;
      if (rdata !== want[i]) begin
        miscompares++;
        $display("[TB] FAIL ext_load_%0d: rdata=%h, want %h", i, rdata, want[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 10'h100, 32'h0, 3, "lw_wait3");
    do_access(1'b0, 1'b1, 2'b01, 1'b0, 10'h106, 32'h0000BEEF, 2, "sh_wait2");
    do_access(1'b1, 1'b0, 2'b01, 1'b1, 10'h106, 32'h0, 1, "lh_wait1");
  endtask

  task automatic test_misaligned();
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 10'h102, 32'h0, 0, "lw_102_mis");
    do_access(1'b0, 1'b1, 2'b01, 1'b0, 10'h001, 32'h1234, 0, "sh_001_mis");
    do_access(1'b1, 1'b0, 2'b11, 1'b0, 10'h043, 32'h0, 0, "l11_043_mis");
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 10'h040, 32'h0, 0, "b2b_lw");
    do_access(1'b1, 1'b1, 2'b10, 1'b0, 10'h044, 32'hCAFEF00D, 0, "b2b_sw");
    do_access(1'b1, 1'b0, 2'b10, 1'b0, 10'h044, 32'h0, 0, "b2b_lw2");
  endtask

  task automatic test_random();
    logic [1:0] sz;
    logic [9:0] a;
    int op;
    for (int i = 0; i < 150; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz[1]) a[1:0] = 2'b00;
      end
      op = $urandom_range(0, 3);
      do_access(op != 1, op == 1 || op == 2, sz, 1'($urandom_range(0, 1)), a,
                $urandom, $urandom_range(0, 2), "random");
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end
  endtask

  task automatic test_reset_in_req();
    mem_read = 1'b1; mem_write = 1'b0; data_size = 2'b10; data_sign = 1'b0;
    addr = 10'h100; dmem_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (dmem_req !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_req_enter: req=%b, want 1", dmem_req);
    end
    rst = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    model_rdata = '0;
    vectors++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0 || rdata_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_in_req: req=%b stall=%b rdata=%h valid=%b, want 0 0 0 0",
               dmem_req, stall, rdata, rdata_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_release: req=%b stall=%b, want 0 0", dmem_req, stall);
    end
    do_access(1'b1, 1'b0, 2'b00, 1'b1, 10'h101, 32'h0, 0, "post_rst_lb");
  endtask

  // Top-level sequence.
  initial begin
    vectors = 0;
    miscompares = 0;
    model_rdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) phys_mem[i] = 32'h0;
    test_reset();
    test_byte_store();
    test_sign_ext();
    test_wait_states();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_reset_in_req();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit for the RV32I pipeline, between the EX/MEM pipeline register and the MEM/WB register. Turns the memory control bits (`mem_read`, `mem_write`, `data_size`, `data_sign`) into a byte-strobed, word-addressed request on the data-memory port. Holds the pipeline with `stall` until memory answers, then presents an aligned, extended load result to writeback. Misaligned accesses are rejected without touching memory.

## Interface
- `WORD_SIZE`, 32, data width; only 32 is supported.
- `ADDR_SIZE`, 10, byte-address width; the word address is `ADDR_SIZE-2` bits.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  load request from EX/MEM.
- `mem_write`  in  1  store request from EX/MEM.
- `data_size`  in  2  access width: 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `data_sign`  in  1  on loads, 1 = sign-extend and 0 = zero-extend; ignored on stores.
- `addr`  in  ADDR_SIZE  byte address (the ALU result).
- `wdata`  in  WORD_SIZE  store data (rs2 value).
- `rdata`  out  WORD_SIZE  extended load result.
- `rdata_valid`  out  1  one-cycle pulse when `rdata` has been updated by a load.
- `stall`  out  1  freezes the PC and all pipeline registers up to and including EX/MEM.
- `misaligned`  out  1  one-cycle flag: the access was dropped.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  ADDR_SIZE-2  word address.
- `dmem_wstrb`  out  4  byte enables.
- `dmem_wdata`  out  WORD_SIZE  lane-replicated store data.
- `dmem_rdata`  in  WORD_SIZE  read word; valid in any cycle where `dmem_ready` is high for a read.
- `dmem_ready`  in  1  completes the outstanding request.

## Operation
- FSM has three states:
  - IDLE: an access is `mem_read | mem_write`. An aligned access raises `stall` combinationally, latches `addr`, `wdata`, size, sign and we, and moves to REQ.
  - REQ: drives `dmem_req=1` with the latched fields. On `dmem_ready=1`, captures `dmem_rdata` if the access is a read and moves to DONE. Holds indefinitely otherwise.
  - DONE: `stall=0` and the pipeline advances. Pulses `rdata_valid` for a read. Returns to IDLE unconditionally; an access is never re-triggered from DONE.
- `stall` is 1 when IDLE sees an aligned access, and throughout REQ.
- `mem_write` and `mem_read` both high: treated as a store only.
- Misalignment rules:
  - half with `addr[0]=1`, or word with `addr[1:0]!=0`, is misaligned;
  - a misaligned access in IDLE asserts `misaligned` combinationally with `stall=0`;
  - there is no memory request, `rdata` is unchanged and `rdata_valid=0`.
- Store formatting, with `lane = addr[1:0]`:
  - byte: wdata = 4 copies of `wdata[7:0]`, strb = `1<<lane`;
  - half: wdata = 2 copies of `wdata[15:0]`, strb = 0011 or 1100 selected by `addr[1]`;
  - word: wdata = `wdata`, strb = 1111.
  - Loads drive strb 0000.
- Load extraction:
  - byte: `dmem_rdata[8*lane +: 8]`;
  - half: `dmem_rdata[16*addr[1] +: 16]`;
  - bit 7 or 15 is replicated when `data_sign=1`, zeros otherwise.
- `rdata` holds its value until the next load completes.

## Timing
- Minimum access is 3 cycles:
  - cycle 0: IDLE, `stall=1`;
  - cycle 1: REQ, `dmem_req=1`, `dmem_ready=1` sampled;
  - cycle 2: DONE, `stall=0`, `rdata_valid=1`.
- Each wait cycle of `dmem_ready` adds one stall cycle.
- Request fields are stable from the first REQ cycle until `dmem_ready` is sampled.
- Reset values:
  - state IDLE;
  - `rdata=0`;
  - `rdata_valid`, `dmem_req`, `dmem_we`, `dmem_wstrb`, `dmem_addr`, `dmem_wdata` all 0;
  - `stall` and `misaligned` 0 unless the IDLE inputs drive them combinationally.
- Reset in REQ abandons the request: `dmem_req=0` in the cycle after the edge. The memory tolerates a dropped request.
- No flush input: the core must not flush EX/MEM while `stall=1`.

## Structure
- Shared package `riscv_pkg` holds:
  - the `data_size` encodings (`SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`);
  - the LSU state enum;
  - `WORD_SIZE`.
- One combinational sub-module, `lsu_align`, does store lane replication, strobe generation, load extraction/extension and the misalignment check. The FSM and registers stay in `load_store_unit`.

## Test plan
- Byte store: `sw` of 0x11223344 at 0x040, then `sb` of 0xAB at 0x041 -> `dmem_wstrb=0010`, `dmem_wdata=0xABABABAB`. A following `lw` of 0x040 returns 0x1122AB44, with `stall` high for exactly 2 cycles at `dmem_ready=1`.
- Signed/unsigned loads of word 0x80F0_7F81 at 0x100:
  - `lb` 0x100 -> 0xFFFFFF81;
  - `lbu` 0x100 -> 0x00000081;
  - `lh` 0x102 -> 0xFFFF80F0;
  - `lhu` 0x102 -> 0x000080F0.
- Wait states: `dmem_ready` held low for 3 REQ cycles on a load -> `stall` high for 5 cycles, request fields constant, then a single `rdata_valid` pulse.
- Misaligned: `lw` at 0x102 and `sh` at 0x001 -> `misaligned=1` for 1 cycle each, `stall=0`, no `dmem_req`, `rdata` unchanged.
- Back-to-back: `lw` immediately followed by `sw` -> DONE then IDLE, and the second request starts exactly one cycle after DONE.
- Reset in REQ with `dmem_ready=0` -> next cycle state IDLE, `dmem_req=0`, `stall=0`, `rdata=0`.
